// File: rtl/rpn_pkg.sv
// Shared definitions for the RPN stack: command codes and FSM state encoding.
package rpn_pkg;

  localparam logic [1:0] CMD_NOP  = 2'b00;
  localparam logic [1:0] CMD_PUSH = 2'b01;
  localparam logic [1:0] CMD_POP  = 2'b10;
  localparam logic [1:0] CMD_EXEC = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StWb   = 2'b10
  } state_e;

endpackage

// File: rtl/rpn_stack_mem.sv
// DEPTH x WIDTH register file: one synchronous write port, two combinational read ports.
// Contents are intentionally not reset; occupancy is tracked by the owner.
module rpn_stack_mem #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr_a,
  input  logic [$clog2(DEPTH)-1:0] raddr_b,
  output logic [WIDTH-1:0]         rdata_a,
  output logic [WIDTH-1:0]         rdata_b
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Single write port, no reset on the storage array.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_a = mem_q[raddr_a];
  assign rdata_b = mem_q[raddr_b];

endmodule

// File: rtl/rpn_stack.sv
// RPN operand stack feeding an external adder. PUSH/POP complete in one cycle;
// EXEC registers the top two operands, waits one cycle for the adder, then writes
// the sum back in place of them. Optional build macro: RPN_STACK_STICKY_ERR_EN
// makes err_ovf/err_unf hold until the next accepted NOP instead of pulsing.
module rpn_stack
  import rpn_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd,
  output logic                       cmd_ready,
  input  logic [WIDTH-1:0]           data_in,
  output logic [WIDTH-1:0]           op_a,
  output logic [WIDTH-1:0]           op_b,
  input  logic [WIDTH-1:0]           alu_s,
  input  logic                       alu_co,
  output logic [WIDTH-1:0]           top,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       pop_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full,
  output logic                       err_ovf,
  output logic                       err_unf,
  output logic                       carry
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

`ifdef RPN_STACK_STICKY_ERR_EN
  localparam bit Sticky = 1'b1;
`else
  localparam bit Sticky = 1'b0;
`endif

  state_e           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic [WIDTH-1:0] pop_data_q, pop_data_d;
  logic             pop_valid_q, pop_valid_d;
  logic             carry_q, carry_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  logic             accept;
  logic             is_empty, is_full, has_two;
  logic             ovf_set, unf_set, err_clr;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr;
  logic [WIDTH-1:0] mem_wdata;
  logic [AW-1:0]    idx_top, idx_sec;
  logic [WIDTH-1:0] rd_top, rd_sec;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign has_two  = (count_q >= CW'(2));
  assign accept   = cmd_valid && (state_q == StIdle);

  // Index arithmetic wraps modulo DEPTH, so count == DEPTH still maps to DEPTH-1.
  assign idx_top = count_q[AW-1:0] - AW'(1);
  assign idx_sec = count_q[AW-1:0] - AW'(2);

  rpn_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we      (mem_we),
    .waddr   (mem_waddr),
    .wdata   (mem_wdata),
    .raddr_a (idx_sec),
    .raddr_b (idx_top),
    .rdata_a (rd_sec),
    .rdata_b (rd_top)
  );

  // Next-state logic: command decode in IDLE, fixed EXEC -> WB -> IDLE sequence.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    carry_d     = carry_q;
    mem_we      = 1'b0;
    mem_waddr   = count_q[AW-1:0];
    mem_wdata   = data_in;
    ovf_set     = 1'b0;
    unf_set     = 1'b0;
    err_clr     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          case (cmd)
            CMD_NOP: begin
              err_clr = 1'b1;
            end
            CMD_PUSH: begin
              if (is_full) begin
                ovf_set = 1'b1;
              end else begin
                mem_we  = 1'b1;
                count_d = count_q + CW'(1);
              end
            end
            CMD_POP: begin
              if (is_empty) begin
                unf_set = 1'b1;
              end else begin
                count_d     = count_q - CW'(1);
                pop_data_d  = rd_top;
                pop_valid_d = 1'b1;
              end
            end
            CMD_EXEC: begin
              if (has_two) begin
                op_a_d  = rd_sec;
                op_b_d  = rd_top;
                state_d = StExec;
              end else begin
                unf_set = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      StExec: begin
        // Adder settle cycle.
        state_d = StWb;
      end
      StWb: begin
        mem_we    = 1'b1;
        mem_waddr = idx_sec;
        mem_wdata = alu_s;
        count_d   = count_q - CW'(1);
        carry_d   = alu_co;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Error flags: pulse for one cycle, or hold until an accepted NOP when sticky.
  always_comb begin
    err_ovf_d = ovf_set | (Sticky & err_ovf_q & ~err_clr);
    err_unf_d = unf_set | (Sticky & err_unf_q & ~err_clr);
  end

  // State registers; reset aborts any in-flight EXEC/WB without write-back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      count_q     <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      carry_q     <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_unf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      carry_q     <= carry_d;
      err_ovf_q   <= err_ovf_d;
      err_unf_q   <= err_unf_d;
    end
  end

  assign cmd_ready = (state_q == StIdle);
  assign op_a      = op_a_q;
  assign op_b      = op_b_q;
  assign top       = is_empty ? '0 : rd_top;
  assign pop_data  = pop_data_q;
  assign pop_valid = pop_valid_q;
  assign count     = count_q;
  assign empty     = is_empty;
  assign full      = is_full;
  assign err_ovf   = err_ovf_q;
  assign err_unf   = err_unf_q;
  assign carry     = carry_q;

endmodule

// File: tb/tb_rpn_stack.sv
// Directed bench for rpn_stack. Follows RPN_STACK_STICKY_ERR_EN to pick the
// expected error-flag behaviour one cycle after an offending command.
module tb_rpn_stack;
  import rpn_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 8;

`ifdef RPN_STACK_STICKY_ERR_EN
  localparam logic StickyExp = 1'b1;
`else
  localparam logic StickyExp = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic [1:0]       cmd;
  logic             cmd_ready;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] alu_s;
  logic             alu_co;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] pop_data;
  logic             pop_valid;
  logic [3:0]       count;
  logic             empty, full;
  logic             err_ovf, err_unf, carry;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Downstream adder model.
  assign {alu_co, alu_s} = {1'b0, op_a} + {1'b0, op_b};

  rpn_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd       (cmd),
    .cmd_ready (cmd_ready),
    .data_in   (data_in),
    .op_a      (op_a),
    .op_b      (op_b),
    .alu_s     (alu_s),
    .alu_co    (alu_co),
    .top       (top),
    .pop_data  (pop_data),
    .pop_valid (pop_valid),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .err_ovf   (err_ovf),
    .err_unf   (err_unf),
    .carry     (carry)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer one command for one accepted cycle; returns #1 after the accepting edge.
  task automatic issue(input logic [1:0] c, input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) check_eq("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd       = c;
    data_in   = d;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    data_in   = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd       = CMD_NOP;
    data_in   = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_ready", 32'(cmd_ready), 32'd1);
    check_eq("rst_top", 32'(top), 32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_full", 32'(full), 32'd0);
    check_eq("rst_opa", 32'(op_a), 32'd0);
    check_eq("rst_errs", 32'({err_ovf, err_unf, pop_valid, carry}), 32'd0);
    rst_n = 1'b1;
    step();

    // Two pushes, then 5 + 3
    issue(CMD_PUSH, 8'h05);
    check_eq("push1_ready", 32'(cmd_ready), 32'd1);
    issue(CMD_PUSH, 8'h03);
    check_eq("push2_count", 32'(count), 32'd2);
    check_eq("push2_top", 32'(top), 32'h03);
    issue(CMD_EXEC, 8'h00);
    check_eq("exec_opa", 32'(op_a), 32'h05);
    check_eq("exec_opb", 32'(op_b), 32'h03);
    check_eq("exec_ready0", 32'(cmd_ready), 32'd0);
    step();
    check_eq("wb_ready0", 32'(cmd_ready), 32'd0);
    step();
    check_eq("exec_ready1", 32'(cmd_ready), 32'd1);
    check_eq("exec_count", 32'(count), 32'd1);
    check_eq("exec_top", 32'(top), 32'h08);
    check_eq("exec_carry", 32'(carry), 32'd0);
    check_eq("exec_opa_hold", 32'(op_a), 32'h05);

    // Pop the result
    issue(CMD_POP, 8'h00);
    check_eq("pop_valid", 32'(pop_valid), 32'd1);
    check_eq("pop_data", 32'(pop_data), 32'h08);
    check_eq("pop_count", 32'(count), 32'd0);
    check_eq("pop_top_empty", 32'(top), 32'd0);
    step();
    check_eq("pop_valid_pulse", 32'(pop_valid), 32'd0);

    // 0xF0 + 0x20 wraps with carry
    issue(CMD_PUSH, 8'hF0);
    issue(CMD_PUSH, 8'h20);
    issue(CMD_EXEC, 8'h00);
    step();
    step();
    check_eq("wrap_top", 32'(top), 32'h10);
    check_eq("wrap_carry", 32'(carry), 32'd1);
    check_eq("wrap_count", 32'(count), 32'd1);
    issue(CMD_POP, 8'h00);
    check_eq("wrap_pop", 32'(pop_data), 32'h10);

    // POP when empty
    issue(CMD_POP, 8'h00);
    check_eq("unf_pop_flag", 32'(err_unf), 32'd1);
    check_eq("unf_pop_count", 32'(count), 32'd0);
    check_eq("unf_pop_valid", 32'(pop_valid), 32'd0);
    step();
    check_eq("unf_pop_hold", 32'(err_unf), 32'(StickyExp));
    issue(CMD_NOP, 8'h00);
    check_eq("unf_pop_clr", 32'(err_unf), 32'd0);

    // EXEC with a single entry
    issue(CMD_PUSH, 8'h11);
    issue(CMD_EXEC, 8'h00);
    check_eq("unf_exec_flag", 32'(err_unf), 32'd1);
    check_eq("unf_exec_count", 32'(count), 32'd1);
    check_eq("unf_exec_ready", 32'(cmd_ready), 32'd1);
    check_eq("unf_exec_top", 32'(top), 32'h11);
    step();
    check_eq("unf_exec_hold", 32'(err_unf), 32'(StickyExp));
    issue(CMD_NOP, 8'h00);
    issue(CMD_POP, 8'h00);

    // Fill, then overflow
    for (int i = 0; i < 8; i++) begin
      issue(CMD_PUSH, 8'(8'h10 + i));
    end
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_count", 32'(count), 32'd8);
    issue(CMD_PUSH, 8'hAA);
    check_eq("ovf_flag", 32'(err_ovf), 32'd1);
    check_eq("ovf_top", 32'(top), 32'h17);
    check_eq("ovf_count", 32'(count), 32'd8);
    check_eq("ovf_full", 32'(full), 32'd1);
    step();
    check_eq("ovf_hold", 32'(err_ovf), 32'(StickyExp));
    issue(CMD_NOP, 8'h00);
    check_eq("ovf_clr", 32'(err_ovf), 32'd0);

    // Reset during WB
    issue(CMD_EXEC, 8'h00);
    check_eq("full_exec_opa", 32'(op_a), 32'h16);
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rstwb_count", 32'(count), 32'd0);
    check_eq("rstwb_ready", 32'(cmd_ready), 32'd1);
    check_eq("rstwb_opa", 32'(op_a), 32'd0);
    check_eq("rstwb_carry", 32'(carry), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check_eq("rstwb_after_count", 32'(count), 32'd0);
    check_eq("rstwb_after_empty", 32'(empty), 32'd1);
    check_eq("rstwb_after_carry", 32'(carry), 32'd0);
    issue(CMD_PUSH, 8'h42);
    check_eq("rstwb_push_top", 32'(top), 32'h42);
    check_eq("rstwb_push_count", 32'(count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
